header_classify_stage: RTL

- Parametrised input stage for the router output-port-lookup pipeline.
- Buffers the AXI-Stream packet stream in an internal FIFO of configurable depth and drives it out through a fully handshaked output register.
- Classifies the header beat of every packet against the per-port MAC table and updates saturating statistics counters.
- Sits between the RX queues and the lookup stage; data and TUSER pass through unmodified.

---
 rtl/header_classify_stage.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/header_classify_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : header_classify_stage                                        |
// | Description : Input stage of the output-port-lookup pipeline. Buffers the   |
// |               AXI-Stream in a small FIFO and drives it out through a fully  |
// |               handshaked register. Classifies each packet header beat      |
// |               against the per-port MAC table and keeps saturating counters. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module header_classify_stage #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int FIFO_DEPTH_BITS    = 2,
  parameter int NUM_PORTS          = 4,
  parameter int SRC_PORT_POS       = 16
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESETN,
  input  logic [C_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic                              S_AXIS_TLAST,
  output logic [C_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
  output logic [C_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
  output logic                              M_AXIS_TLAST,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  input  logic [48*NUM_PORTS-1:0]           mac_table,
  input  logic                              counters_clear,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     pkt_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     arp_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     ipv4_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     ospf_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     non_ip_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     wrong_mac_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     cpu_count
);

  localparam int STRB_W  = C_AXIS_DATA_WIDTH / 8;
  localparam int ENTRY_W = 1 + C_AXIS_TUSER_WIDTH + STRB_W + C_AXIS_DATA_WIDTH;
  localparam int DEPTH   = 1 << FIFO_DEPTH_BITS;
  localparam int NUM_CNT = 7;

  // Counter slots
  localparam int CNT_PKT    = 0;
  localparam int CNT_ARP    = 1;
  localparam int CNT_IPV4   = 2;
  localparam int CNT_OSPF   = 3;
  localparam int CNT_NON_IP = 4;
  localparam int CNT_WRONG  = 5;
  localparam int CNT_CPU    = 6;

  localparam logic [FIFO_DEPTH_BITS-1:0]    PTR_ONE = FIFO_DEPTH_BITS'(1);
  localparam logic [FIFO_DEPTH_BITS:0]      OCC_ONE = (FIFO_DEPTH_BITS + 1)'(1);
  localparam logic [C_S_AXI_DATA_WIDTH-1:0] CNT_ONE = C_S_AXI_DATA_WIDTH'(1);
  localparam logic [C_S_AXI_DATA_WIDTH-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------- FIFO
  logic [ENTRY_W-1:0]         mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
  logic [FIFO_DEPTH_BITS:0]   occupancy;
  logic [ENTRY_W-1:0]         head;
  logic                       wr_en;
  logic                       rd_en;

  // Occupancy never exceeds DEPTH, so the MSB alone flags "full".
  assign S_AXIS_TREADY = ~occupancy[FIFO_DEPTH_BITS];
  assign wr_en         = S_AXIS_TVALID & S_AXIS_TREADY;
  assign rd_en         = (occupancy != '0) & (~M_AXIS_TVALID | M_AXIS_TREADY);
  assign head          = mem[rd_ptr];

  // Storage array; no reset needed, validity is tracked by occupancy
  always_ff @(posedge AXI_ACLK) begin
    if (wr_en) begin
      mem[wr_ptr] <= {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};
    end
  end

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap freely
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   occupancy <= occupancy + OCC_ONE;
        2'b01:   occupancy <= occupancy - OCC_ONE;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Output register: reload from the FIFO head whenever it is free or being consumed
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TSTRB  <= '0;
      M_AXIS_TUSER  <= '0;
      M_AXIS_TLAST  <= 1'b0;
    end else if (rd_en) begin
      M_AXIS_TVALID <= 1'b1;
      {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TDATA} <= head;
    end else if (M_AXIS_TREADY) begin
      // Consumed with nothing behind it: go idle, data is left as-is
      M_AXIS_TVALID <= 1'b0;
    end
  end

  // ------------------------------------------------------ classification
  logic                 sop;
  logic                 classify;
  logic [47:0]          dst_mac;
  logic [15:0]          ethertype;
  logic [3:0]           ip_version;
  logic [7:0]           ip_proto;
  logic [7:0]           src_port;
  logic [NUM_PORTS-1:0] port_valid;
  logic [NUM_PORTS-1:0] port_hit;
  logic                 is_cpu;
  logic                 is_bcast;
  logic [NUM_CNT-1:0]   inc;

  assign dst_mac    = S_AXIS_TDATA[255:208];
  assign ethertype  = S_AXIS_TDATA[159:144];
  assign ip_version = S_AXIS_TDATA[143:140];
  assign ip_proto   = S_AXIS_TDATA[71:64];
  assign src_port   = S_AXIS_TUSER[SRC_PORT_POS +: 8];
  assign classify   = wr_en & sop;
  assign is_cpu     = |(src_port & 8'hAA);
  assign is_bcast   = (dst_mac == 48'hFFFF_FFFF_FFFF);

  generate
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      assign port_valid[i] = src_port[2*i];
      assign port_hit[i]   = src_port[2*i] & (dst_mac == mac_table[48*i +: 48]);
    end
  endgenerate

  // Start-of-packet tracking: the beat after a TLAST (or after reset) is a header
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      sop <= 1'b1;
    end else if (wr_en) begin
      sop <= S_AXIS_TLAST;
    end
  end

  // Per-packet counter selection; MAC and ethertype categories are independent
  always_comb begin
    inc = '0;
    inc[CNT_PKT] = 1'b1;
    if (is_cpu) begin
      inc[CNT_CPU] = 1'b1;
    end else if (!(|port_valid) || !((|port_hit) || is_bcast)) begin
      inc[CNT_WRONG] = 1'b1;
    end
    if (ethertype == 16'h0806) begin
      inc[CNT_ARP] = 1'b1;
    end else if ((ethertype == 16'h0800) && (ip_version == 4'd4)) begin
      inc[CNT_IPV4] = 1'b1;
      if (ip_proto == 8'd89) inc[CNT_OSPF] = 1'b1;
    end else begin
      inc[CNT_NON_IP] = 1'b1;
    end
  end

  logic [C_S_AXI_DATA_WIDTH-1:0] cnt [NUM_CNT];

  // Statistics counters: clear wins over a same-cycle increment, increments saturate
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      for (int k = 0; k < NUM_CNT; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CNT; k++) begin
        if (counters_clear) begin
          cnt[k] <= '0;
        end else if (classify && inc[k] && (cnt[k] != CNT_MAX)) begin
          cnt[k] <= cnt[k] + CNT_ONE;
        end
      end
    end
  end

  assign pkt_count       = cnt[CNT_PKT];
  assign arp_count       = cnt[CNT_ARP];
  assign ipv4_count      = cnt[CNT_IPV4];
  assign ospf_count      = cnt[CNT_OSPF];
  assign non_ip_count    = cnt[CNT_NON_IP];
  assign wrong_mac_count = cnt[CNT_WRONG];
  assign cpu_count       = cnt[CNT_CPU];

endmodule
`default_nettype wire
